// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic GEMM engine.
// Holds the FSM state type, the default parameter values and a helper
// that pulls one lane out of a packed multi-lane word. Lane 0 sits in the
// most significant bits.
package tpu_pkg;

    localparam int DEF_ARRAY_DIM = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_DIM_W     = 8;
    localparam int DEF_ADDR_W    = 16;

    // Widest packed word the lane helper accepts
    localparam int LANE_MAX_W    = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FIN     = 2'd3
    } gemm_state_e;

    // Return lane 'lane' (width 'width', at most 32) of a word holding 'lanes'
    // lanes, lane 0 in the MSBs.
    function automatic logic [31:0] lane_sel(input logic [LANE_MAX_W-1:0] word,
                                             input int lanes,
                                             input int width,
                                             input int lane);
        logic [LANE_MAX_W-1:0] sh;
        logic [31:0]           mask;
        sh = word >> ((lanes - 1 - lane) * width);
        if (width >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/systolic_gemm_if.sv
// Bus bundle between the GEMM engine and its operand/result buffers.
// slave  : engine side (takes start/dims/read data, drives control + writes)
// master : controller/buffer side
interface systolic_gemm_if
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM = DEF_ARRAY_DIM,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DIM_W     = DEF_DIM_W,
    parameter int ADDR_W    = DEF_ADDR_W
);
    logic                        start;
    logic [DIM_W-1:0]            m;
    logic [DIM_W-1:0]            n;
    logic [DIM_W-1:0]            k;
    logic                        busy;
    logic                        done;
    logic                        wr_en_a;
    logic                        wr_en_b;
    logic [ADDR_W-1:0]           index_a;
    logic [ADDR_W-1:0]           index_b;
    logic [ARRAY_DIM*DATA_W-1:0] data_in_a;
    logic [ARRAY_DIM*DATA_W-1:0] data_in_b;
    logic                        wr_en_o;
    logic [ADDR_W-1:0]           index_o;
    logic [ARRAY_DIM*ACC_W-1:0]  data_out_o;

    modport slave (
        input  start, m, n, k, data_in_a, data_in_b,
        output busy, done, wr_en_a, wr_en_b, index_a, index_b,
               wr_en_o, index_o, data_out_o
    );

    modport master (
        output start, m, n, k, data_in_a, data_in_b,
        input  busy, done, wr_en_a, wr_en_b, index_a, index_b,
               wr_en_o, index_o, data_out_o
    );
endinterface

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary systolic array.
// Ports: clk, rst (sync, active high), clear (zero the accumulator),
//        a_in/b_in operands, a_out/b_out registered pass-through
//        (right and down), acc accumulated dot product.
// Macro SYSTOLIC_GEMM_SAT_EN: accumulator saturates instead of wrapping.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);
    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic [ACC_W-1:0]  acc_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;

`ifdef SYSTOLIC_GEMM_SAT_EN
    localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    logic [SUM_W-1:0] sum_s;

    // Multiply-accumulate, clamped at the accumulator's all-ones value
    always_comb begin
        prod_s = PROD_W'(a_in) * PROD_W'(b_in);
        sum_s  = SUM_W'(acc_r) + SUM_W'(prod_s);
        if (sum_s > SUM_W'({ACC_W{1'b1}})) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
    end
`else
    // Multiply-accumulate, wrapping modulo the accumulator width
    always_comb begin
        prod_s     = PROD_W'(a_in) * PROD_W'(b_in);
        acc_next_s = acc_r + ACC_W'(prod_s);
    end
`endif

    // Operand pass-through registers and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= clear ? '0 : acc_next_s;
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign acc   = acc_r;
endmodule

// File: rtl/systolic_gemm.sv
// Tiled GEMM engine C[m][n] = A[m][k] x B[k][n] on a D x D output-stationary
// systolic array (D = ARRAY_DIM). Tiles run column-tile outer, row-tile inner.
// Each tile: COMPUTE (k + 2D - 1 cycles) streams operands through skew
// registers, then WRITE (D cycles) emits one C row per cycle.
// Ports: clk, rst (sync, active high), bus (systolic_gemm_if.slave):
//   start/m/n/k request, busy/done status, index_a/index_b buffer reads with
//   data_in_a/data_in_b one cycle later, wr_en_o/index_o/data_out_o writes.
// Macro SYSTOLIC_GEMM_SAT_EN: saturating accumulators (default wraps).
module systolic_gemm
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM = DEF_ARRAY_DIM,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DIM_W     = DEF_DIM_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    systolic_gemm_if.slave   bus
);
    localparam int D    = ARRAY_DIM;
    localparam int RS_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [ADDR_W-1:0] D_A      = ADDR_W'(ARRAY_DIM);
    localparam logic [ADDR_W-1:0] D_M1     = ADDR_W'(ARRAY_DIM - 1);
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(2 * ARRAY_DIM - 2);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    gemm_state_e       state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0] m_r, m_s, n_r, n_s, k_r, k_s;
    logic [ADDR_W-1:0] mt_row_r, mt_row_s, nt_col_r, nt_col_s;
    logic [ADDR_W-1:0] base_a_r, base_a_s, base_b_r, base_b_s, base_o_r, base_o_s;
    logic [ADDR_W-1:0] index_a_r, index_a_s, index_b_r, index_b_s, index_o_r, index_o_s;
    logic              busy_r, busy_s, done_r, done_s, wr_en_o_r, wr_en_o_s;
    logic              clear_s;
    logic [D*ACC_W-1:0] data_out_r, data_out_s, row_word_s;
    logic [DIM_W-1:0]  m_in_s, n_in_s, k_in_s;
    logic [RS_W-1:0]   row_sel_s;
    logic              valid_s;

    logic [D-1:0][DATA_W-1:0]      a_raw_s, b_raw_s, a_lane_s, b_lane_s;
    logic [D-1:0][DATA_W-1:0]      a_edge_s, b_edge_s;
    logic [D-1:0][D:0][DATA_W-1:0] a_h_s;
    logic [D:0][D-1:0][DATA_W-1:0] b_v_s;
    logic [D-1:0][D-1:0][ACC_W-1:0] acc_s;

    assign m_in_s = bus.m;
    assign n_in_s = bus.n;
    assign k_in_s = bus.k;

    // FSM next state, tile bookkeeping and next values of every output register
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        m_s        = m_r;
        n_s        = n_r;
        k_s        = k_r;
        mt_row_s   = mt_row_r;
        nt_col_s   = nt_col_r;
        base_a_s   = base_a_r;
        base_b_s   = base_b_r;
        base_o_s   = base_o_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        clear_s    = 1'b0;
        wr_en_o_s  = 1'b0;
        index_o_s  = index_o_r;
        data_out_s = data_out_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((m_in_s != '0) && (n_in_s != '0) && (k_in_s != '0)) begin
                        state_s  = ST_COMPUTE;
                        m_s      = ADDR_W'(m_in_s);
                        n_s      = ADDR_W'(n_in_s);
                        k_s      = ADDR_W'(k_in_s);
                        cnt_s    = '0;
                        mt_row_s = '0;
                        nt_col_s = '0;
                        base_a_s = '0;
                        base_b_s = '0;
                        base_o_s = '0;
                        busy_s   = 1'b1;
                        clear_s  = 1'b1;
                    end else begin
                        // Degenerate request: acknowledge without any traffic
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_r == k_r + LAST_OFF) begin
                    state_s = ST_WRITE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + ONE_A;
                end
            end
            ST_WRITE: begin
                wr_en_o_s  = (mt_row_r + cnt_r) < m_r;
                index_o_s  = base_o_r + mt_row_r + cnt_r;
                data_out_s = row_word_s;
                if (cnt_r == D_M1) begin
                    cnt_s = '0;
                    if ((mt_row_r + D_A) < m_r) begin
                        state_s  = ST_COMPUTE;
                        clear_s  = 1'b1;
                        mt_row_s = mt_row_r + D_A;
                        base_a_s = base_a_r + k_r;
                    end else if ((nt_col_r + D_A) < n_r) begin
                        state_s  = ST_COMPUTE;
                        clear_s  = 1'b1;
                        mt_row_s = '0;
                        base_a_s = '0;
                        nt_col_s = nt_col_r + D_A;
                        base_b_s = base_b_r + k_r;
                        base_o_s = base_o_r + m_r;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    cnt_s = cnt_r + ONE_A;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
        // Read addresses for the coming cycle: kk = cnt for kk < k
        if ((state_s == ST_COMPUTE) && (cnt_s < k_s)) begin
            index_a_s = base_a_s + cnt_s;
            index_b_s = base_b_s + cnt_s;
        end else begin
            index_a_s = '0;
            index_b_s = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            m_r        <= '0;
            n_r        <= '0;
            k_r        <= '0;
            mt_row_r   <= '0;
            nt_col_r   <= '0;
            base_a_r   <= '0;
            base_b_r   <= '0;
            base_o_r   <= '0;
            index_a_r  <= '0;
            index_b_r  <= '0;
            index_o_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_en_o_r  <= 1'b0;
            data_out_r <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            m_r        <= m_s;
            n_r        <= n_s;
            k_r        <= k_s;
            mt_row_r   <= mt_row_s;
            nt_col_r   <= nt_col_s;
            base_a_r   <= base_a_s;
            base_b_r   <= base_b_s;
            base_o_r   <= base_o_s;
            index_a_r  <= index_a_s;
            index_b_r  <= index_b_s;
            index_o_r  <= index_o_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            wr_en_o_r  <= wr_en_o_s;
            data_out_r <= data_out_s;
        end
    end

    // Read data for kk arrives at COMPUTE cycle kk+1; anything else feeds zeros
    // so the pipeline flushes clean between tiles.
    assign valid_s   = (state_r == ST_COMPUTE) && (cnt_r != '0) && (cnt_r <= k_r);
    assign row_sel_s = cnt_r[RS_W-1:0];

    // Accumulator row selected by the WRITE counter, lane 0 in the MSBs
    always_comb begin
        row_word_s = '0;
        for (int c = 0; c < D; c++) begin
            row_word_s[(D-1-c)*ACC_W +: ACC_W] = acc_s[row_sel_s][c];
        end
    end

    for (genvar r = 0; r < D; r++) begin : g_lane
        assign a_raw_s[r]  = DATA_W'(lane_sel(LANE_MAX_W'(bus.data_in_a), D, DATA_W, r));
        assign b_raw_s[r]  = DATA_W'(lane_sel(LANE_MAX_W'(bus.data_in_b), D, DATA_W, r));
        // Edge-tile lanes past m or n carry zero operands
        assign a_lane_s[r] = (valid_s && ((mt_row_r + ADDR_W'(r)) < m_r)) ? a_raw_s[r] : '0;
        assign b_lane_s[r] = (valid_s && ((nt_col_r + ADDR_W'(r)) < n_r)) ? b_raw_s[r] : '0;

        if (r == 0) begin : g_noskew
            assign a_edge_s[r] = a_lane_s[r];
            assign b_edge_s[r] = b_lane_s[r];
        end else begin : g_skew
            logic [DATA_W-1:0] sa_r [r];
            logic [DATA_W-1:0] sb_r [r];
            // Lane r is delayed r cycles so wavefronts meet on the diagonal
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) begin
                        sa_r[i] <= '0;
                        sb_r[i] <= '0;
                    end
                end else begin
                    sa_r[0] <= a_lane_s[r];
                    sb_r[0] <= b_lane_s[r];
                    for (int i = 1; i < r; i++) begin
                        sa_r[i] <= sa_r[i-1];
                        sb_r[i] <= sb_r[i-1];
                    end
                end
            end
            assign a_edge_s[r] = sa_r[r-1];
            assign b_edge_s[r] = sb_r[r-1];
        end

        assign a_h_s[r][0] = a_edge_s[r];
        assign b_v_s[0][r] = b_edge_s[r];
    end

    for (genvar r = 0; r < D; r++) begin : g_row
        for (genvar c = 0; c < D; c++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (clear_s),
                .a_in  (a_h_s[r][c]),
                .b_in  (b_v_s[r][c]),
                .a_out (a_h_s[r][c+1]),
                .b_out (b_v_s[r+1][c]),
                .acc   (acc_s[r][c])
            );
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.wr_en_a    = 1'b0;
    assign bus.wr_en_b    = 1'b0;
    assign bus.index_a    = index_a_r;
    assign bus.index_b    = index_b_r;
    assign bus.wr_en_o    = wr_en_o_r;
    assign bus.index_o    = index_o_r;
    assign bus.data_out_o = data_out_r;
endmodule

// File: tb/tb_systolic_gemm.sv
// Self-checking bench for systolic_gemm: matrices are generated in the bench,
// laid out in buffer memories, and C is predicted with a plain triple loop.
module tb_systolic_gemm;
    localparam int D    = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int DIMW = 8;
    localparam int ADW  = 16;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_gemm_if #(.ARRAY_DIM(D), .DATA_W(DW), .ACC_W(AW), .DIM_W(DIMW), .ADDR_W(ADW)) bus ();
    systolic_gemm #(.ARRAY_DIM(D), .DATA_W(DW), .ACC_W(AW), .DIM_W(DIMW), .ADDR_W(ADW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [D*DW-1:0] mem_a [1024];
    logic [D*DW-1:0] mem_b [1024];
    int amat [16][256];
    int bmat [256][16];

    typedef struct {
        int              idx;
        logic [D*AW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int wr_cnt   = 0;
    int done_cnt = 0;
    logic [D*AW-1:0] cap [2048];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // buffer memories: read data one cycle after the index
    always @(posedge clk) begin
        bus.data_in_a <= mem_a[bus.index_a[9:0]];
        bus.data_in_b <= mem_b[bus.index_b[9:0]];
    end

    // compare process: every write against the predicted queue
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("rd_only", {63'd0, bus.wr_en_a | bus.wr_en_b}, 64'd0);
            if (bus.wr_en_o === 1'b1) begin
                wr_t e;
                wr_cnt++;
                cap[bus.index_o[10:0]] = bus.data_out_o;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write index=%0d", bus.index_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_index", 64'(bus.index_o), 64'(e.idx));
                    check("wr_data", 64'(bus.data_out_o), 64'(e.data));
                end
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    function automatic int cval(input int row, input int col, input int k);
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(amat[row][kk]) * longint'(bmat[kk][col]);
`ifdef SYSTOLIC_GEMM_SAT_EN
        if (s > 65535) s = 65535;
`else
        s = s % 65536;
`endif
        return int'(s);
    endfunction

    // mode 0 random, 1 identity A with B[i][j]=4i+j, 2 all ones, 3 all 255
    task automatic build(input int m, input int n, input int k, input int mode);
        int mt_n, nt_n;
        mt_n = (m + D - 1) / D;
        nt_n = (n + D - 1) / D;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = D*DW'($urandom);
            mem_b[i] = D*DW'($urandom);
        end
        for (int r = 0; r < 16; r++)
            for (int kk = 0; kk < k; kk++) begin
                case (mode)
                    1: begin amat[r][kk] = (r == kk) ? 1 : 0; bmat[kk][r] = 4 * kk + r; end
                    2: begin amat[r][kk] = 1;   bmat[kk][r] = 1;   end
                    3: begin amat[r][kk] = 255; bmat[kk][r] = 255; end
                    default: begin amat[r][kk] = int'($urandom_range(0, 255)); bmat[kk][r] = int'($urandom_range(0, 255)); end
                endcase
            end
        // buffer layout; out-of-range lanes keep random filler
        for (int t = 0; t < mt_n; t++)
            for (int kk = 0; kk < k; kk++)
                for (int r = 0; r < D; r++)
                    if (t * D + r < m) mem_a[t*k+kk][(D-1-r)*DW +: DW] = DW'(amat[t*D+r][kk]);
        for (int t = 0; t < nt_n; t++)
            for (int kk = 0; kk < k; kk++)
                for (int c = 0; c < D; c++)
                    if (t * D + c < n) mem_b[t*k+kk][(D-1-c)*DW +: DW] = DW'(bmat[kk][t*D+c]);
        exp_q.delete();
        if (m != 0 && n != 0 && k != 0) begin
            for (int nt = 0; nt < nt_n; nt++)
                for (int mt = 0; mt < mt_n; mt++)
                    for (int i = 0; i < D; i++)
                        if (mt * D + i < m) begin
                            wr_t e;
                            e.idx  = nt * m + mt * D + i;
                            e.data = '0;
                            for (int c = 0; c < D; c++)
                                if (nt * D + c < n)
                                    e.data[(D-1-c)*AW +: AW] = AW'(cval(mt*D+i, nt*D+c, k));
                            exp_q.push_back(e);
                        end
        end
        for (int i = 0; i < 2048; i++) cap[i] = 'x;
    endtask

    task automatic run(input int m, input int n, input int k, input int mode,
                       input bit extra, output int lat);
        int  exp_lat, d0, w0, nwr;
        bit  zero, seen;
        build(m, n, k, mode);
        nwr  = exp_q.size();
        zero = (m == 0) || (n == 0) || (k == 0);
        exp_lat = zero ? 1 : 2 + ((m + D - 1) / D) * ((n + D - 1) / D) * (k + 3 * D - 1);
        d0 = done_cnt;
        w0 = wr_cnt;
        bus.m = DIMW'(m);
        bus.n = DIMW'(n);
        bus.k = DIMW'(k);
        bus.start = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("busy", {63'd0, bus.busy}, {63'd0, !zero});
            if (extra && lat == 5) begin
                bus.start = 1'b1;
                bus.m = 8'd1;
                bus.n = 8'd1;
                bus.k = 8'd1;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout m=%0d n=%0d k=%0d", m, n, k);
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("write_count", 64'(wr_cnt - w0), 64'(nwr));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat, d0, w0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.m = '0;
        bus.n = '0;
        bus.k = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_wr_en_o", {63'd0, bus.wr_en_o}, 64'd0);
        check("rst_index_a", 64'(bus.index_a), 64'd0);
        check("rst_index_o", 64'(bus.index_o), 64'd0);
        check("rst_data_out", 64'(bus.data_out_o), 64'd0);

        // identity x (4i+j): C equals B
        run(4, 4, 4, 1, 1'b0, lat);
        check("id_latency17", 64'(lat), 64'd17);
        check("id_row0", 64'(cap[0]), 64'h0000_0001_0002_0003);
        check("id_row1", 64'(cap[1]), 64'h0004_0005_0006_0007);
        check("id_row2", 64'(cap[2]), 64'h0008_0009_000A_000B);
        check("id_row3", 64'(cap[3]), 64'h000C_000D_000E_000F);

        // ragged edge tiles, all ones
        w0 = wr_cnt;
        run(5, 6, 3, 2, 1'b0, lat);
        check("ones_writes", 64'(wr_cnt - w0), 64'd10);
        check("ones_nt0_r0", 64'(cap[0]), 64'h0003_0003_0003_0003);
        check("ones_nt0_r4", 64'(cap[4]), 64'h0003_0003_0003_0003);
        check("ones_nt1_r0", 64'(cap[5]), 64'h0003_0003_0000_0000);
        check("ones_nt1_r4", 64'(cap[9]), 64'h0003_0003_0000_0000);

        // zero dimensions: done next cycle, no busy, no traffic
        run(4, 4, 0, 0, 1'b0, lat);
        check("k0_latency", 64'(lat), 64'd1);
        run(0, 3, 3, 0, 1'b0, lat);

        // long k with maximal operands: 255*255*255 = 0xFD02FF
        run(4, 4, 255, 3, 1'b0, lat);
`ifdef SYSTOLIC_GEMM_SAT_EN
        check("k255_sat", 64'(cap[2]), 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("k255_wrap", 64'(cap[2]), 64'h02FF_02FF_02FF_02FF);
`endif

        // start while busy is ignored
        run(6, 5, 7, 0, 1'b1, lat);

        // reset in the middle of COMPUTE abandons the job
        build(8, 8, 40, 0);
        d0 = done_cnt;
        bus.m = 8'd8;
        bus.n = 8'd8;
        bus.k = 8'd40;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_index_a", 64'(bus.index_a), 64'd0);
        check("midrst_data_out", 64'(bus.data_out_o), 64'd0);
        repeat (80) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_idle", {63'd0, bus.busy}, 64'd0);
        run(7, 9, 11, 0, 1'b0, lat);

        // randomized shapes
        for (int t = 0; t < 8; t++) begin
            run(int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
                int'($urandom_range(1, 24)), 0, 1'b0, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
